// File: rtl/ac_zone_ctrl.sv
// Multi-zone heat/cool hysteresis controller: one IDLE/HEAT/COOL FSM per zone with
// per-zone operating mode and minimum on/off dwell protection.
module ac_zone_ctrl #(
  parameter int unsigned TEMP_W   = 5,
  parameter int unsigned ZONES    = 2,
  parameter int unsigned HEAT_ON  = 18,
  parameter int unsigned HEAT_OFF = 20,
  parameter int unsigned COOL_ON  = 22,
  parameter int unsigned COOL_OFF = 20,
  parameter int unsigned MIN_ON   = 4,
  parameter int unsigned MIN_OFF  = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [ZONES*TEMP_W-1:0]   temperature,
  input  logic [2*ZONES-1:0]        mode,
  output logic [ZONES-1:0]          heating,
  output logic [ZONES-1:0]          cooling
);

  localparam int unsigned DMAX = (MIN_ON > MIN_OFF) ? MIN_ON : MIN_OFF;
  localparam int unsigned CW   = $clog2(DMAX + 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HEAT = 2'd1,
    ST_COOL = 2'd2
  } state_t;

  if (!((HEAT_ON < HEAT_OFF) && (COOL_OFF < COOL_ON) && (HEAT_ON < COOL_ON) &&
        (HEAT_ON < 2**TEMP_W) && (HEAT_OFF < 2**TEMP_W) &&
        (COOL_ON < 2**TEMP_W) && (COOL_OFF < 2**TEMP_W) &&
        (MIN_ON >= 1) && (MIN_OFF >= 1))) begin : g_param_err
    $error("ac_zone_ctrl: illegal parameter set");
  end

  for (genvar z = 0; z < ZONES; z++) begin : g_zone
    logic [TEMP_W-1:0] w_temp;
    logic              w_heat_ok;
    logic              w_cool_ok;
    state_t            r_state;
    state_t            w_next;
    logic [CW-1:0]     r_dwell;
    logic [CW-1:0]     w_dwell_nxt;
    logic              r_heat;
    logic              r_cool;

    assign w_temp    = temperature[z*TEMP_W +: TEMP_W];
    assign w_heat_ok = mode[2*z];
    assign w_cool_ok = mode[2*z+1];

    // Next-state: mode override beats MIN_ON; IDLE must serve MIN_OFF before re-entry
    always_comb begin
      w_next = r_state;
      case (r_state)
        ST_IDLE: begin
          if (r_dwell >= CW'(MIN_OFF - 1)) begin
            if (w_heat_ok && (w_temp <= TEMP_W'(HEAT_ON)))
              w_next = ST_HEAT;
            else if (w_cool_ok && (w_temp >= TEMP_W'(COOL_ON)))
              w_next = ST_COOL;
          end
        end
        ST_HEAT: begin
          if (!w_heat_ok ||
              ((w_temp >= TEMP_W'(HEAT_OFF)) && (r_dwell >= CW'(MIN_ON - 1))))
            w_next = ST_IDLE;
        end
        ST_COOL: begin
          if (!w_cool_ok ||
              ((w_temp <= TEMP_W'(COOL_OFF)) && (r_dwell >= CW'(MIN_ON - 1))))
            w_next = ST_IDLE;
        end
        default: w_next = ST_IDLE;
      endcase

      if (w_next != r_state)
        w_dwell_nxt = '0;
      else if (r_dwell == CW'(DMAX))
        w_dwell_nxt = r_dwell;
      else
        w_dwell_nxt = r_dwell + CW'(1);
    end

    // Reset saturates dwell so an active state may be entered right after release
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_state <= ST_IDLE;
        r_dwell <= CW'(DMAX);
        r_heat  <= 1'b0;
        r_cool  <= 1'b0;
      end else begin
        r_state <= w_next;
        r_dwell <= w_dwell_nxt;
        r_heat  <= (w_next == ST_HEAT);
        r_cool  <= (w_next == ST_COOL);
      end
    end

    assign heating[z] = r_heat;
    assign cooling[z] = r_cool;
  end

endmodule

// File: tb/tb_ac_zone_ctrl.sv
// Scoreboard bench for ac_zone_ctrl: directed test-plan sequences plus randomized
// temperature/mode traffic, checked against a behavioural per-zone model.
module tb_ac_zone_ctrl;

  localparam int unsigned TW       = 5;
  localparam int unsigned NZ       = 2;
  localparam int unsigned HEAT_ON  = 18;
  localparam int unsigned HEAT_OFF = 20;
  localparam int unsigned COOL_ON  = 22;
  localparam int unsigned COOL_OFF = 20;
  localparam int unsigned MIN_ON   = 4;
  localparam int unsigned MIN_OFF  = 2;

  logic                 clk;
  logic                 rst;
  logic [NZ*TW-1:0]     temperature;
  logic [2*NZ-1:0]      mode;
  logic [NZ-1:0]        heating;
  logic [NZ-1:0]        cooling;

  ac_zone_ctrl #(
    .TEMP_W(TW), .ZONES(NZ), .HEAT_ON(HEAT_ON), .HEAT_OFF(HEAT_OFF),
    .COOL_ON(COOL_ON), .COOL_OFF(COOL_OFF), .MIN_ON(MIN_ON), .MIN_OFF(MIN_OFF)
  ) dut (
    .clk(clk), .rst(rst), .temperature(temperature), .mode(mode),
    .heating(heating), .cooling(cooling)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  logic [2*NZ-1:0] sb[$];

  // Model: what each zone is doing (0 idle, 1 heat, 2 cool) and how long it has done it
  int kind[NZ];
  int age[NZ];

  function automatic void model_reset();
    for (int z = 0; z < NZ; z++) begin
      kind[z] = 0;
      age[z]  = 1000;
    end
  endfunction

  function automatic logic [2*NZ-1:0] model_step();
    logic [NZ-1:0] h;
    logic [NZ-1:0] c;
    for (int z = 0; z < NZ; z++) begin
      int t;
      int nk;
      bit hok;
      bit cok;
      t   = int'(temperature[z*TW +: TW]);
      hok = mode[2*z];
      cok = mode[2*z+1];
      nk  = kind[z];
      if (kind[z] == 0) begin
        if (age[z] + 1 >= int'(MIN_OFF)) begin
          if (hok && t <= int'(HEAT_ON)) nk = 1;
          else if (cok && t >= int'(COOL_ON)) nk = 2;
        end
      end else if (kind[z] == 1) begin
        if (!hok || (t >= int'(HEAT_OFF) && age[z] + 1 >= int'(MIN_ON))) nk = 0;
      end else begin
        if (!cok || (t <= int'(COOL_OFF) && age[z] + 1 >= int'(MIN_ON))) nk = 0;
      end
      if (nk != kind[z]) age[z] = 0;
      else if (age[z] < 1000) age[z] = age[z] + 1;
      kind[z] = nk;
      h[z] = (nk == 1);
      c[z] = (nk == 2);
    end
    return {h, c};
  endfunction

  task automatic set_zone(input int z, input int t, input logic [1:0] m);
    temperature[z*TW +: TW] = TW'(t);
    mode[2*z +: 2] = m;
  endtask

  // Called right after a falling edge: predict the next rising edge, then wait one cycle
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      sb.push_back(model_step());
      @(negedge clk);
    end
  endtask

  task automatic check_now(input string name, input logic [2*NZ-1:0] req);
    n_cmp++;
    if ({heating, cooling} !== req) begin
      n_bad++;
      $display("FAIL %s: got heating=%b cooling=%b, required heating=%b cooling=%b",
               name, heating, cooling, req[2*NZ-1:NZ], req[NZ-1:0]);
    end
  endtask

  // Monitor: pops one expectation per rising edge that had stimulus behind it
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        logic [2*NZ-1:0] e;
        e = sb.pop_front();
        n_cmp++;
        if ({heating, cooling} !== e || (heating & cooling) != '0) begin
          n_bad++;
          $display("FAIL scoreboard @%0t: got heating=%b cooling=%b, required heating=%b cooling=%b",
                   $time, heating, cooling, e[2*NZ-1:NZ], e[NZ-1:0]);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish, got timeout, required completion");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    temperature = '0;
    mode = '0;
    model_reset();
    set_zone(1, 20, 2'b00);
    #12;
    check_now("reset_state", '0);
    @(negedge clk);
    rst = 1'b0;

    // Basic heat and MIN_ON hold
    set_zone(0, 17, 2'b11);
    step(1);
    set_zone(0, 20, 2'b11);
    step(6);
    // MIN_OFF before re-entering heat
    set_zone(0, 17, 2'b11);
    step(5);
    set_zone(0, 20, 2'b11);
    step(6);
    // Cooling thresholds
    set_zone(0, 21, 2'b11);
    step(3);
    set_zone(0, 22, 2'b11);
    step(1);
    set_zone(0, 21, 2'b11);
    step(10);
    set_zone(0, 20, 2'b11);
    step(3);
    // Mode gating and override on zone 1
    set_zone(1, 15, 2'b10);
    step(3);
    set_zone(1, 25, 2'b10);
    step(2);
    set_zone(1, 25, 2'b01);
    step(4);
    // Zone independence
    set_zone(0, 16, 2'b11);
    set_zone(1, 24, 2'b11);
    step(3);
    set_zone(0, 16, 2'b00);
    step(3);
    // Async reset in the middle of cooling
    set_zone(0, 25, 2'b11);
    step(6);
    #2;
    rst = 1'b1;
    #1;
    check_now("async_reset_drop", '0);
    model_reset();
    set_zone(0, 23, 2'b11);
    @(negedge clk);
    check_now("held_in_reset", '0);
    rst = 1'b0;
    step(2);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      for (int z = 0; z < NZ; z++) begin
        if ($urandom_range(9, 0) == 0)
          mode[2*z +: 2] = 2'($urandom_range(3, 0));
        if ($urandom_range(1, 0) == 0)
          temperature[z*TW +: TW] = TW'($urandom_range(26, 14));
      end
      step(1);
    end

    @(negedge clk);
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending expectations, required 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ac_zone_ctrl.md
Name: ac_zone_ctrl

Overview:
Multi-zone air-conditioning controller; next generation of the single-zone heat/cool hysteresis controller. One independent IDLE/HEAT/COOL state machine per zone, parametrised temperature width, thresholds and zone count. Adds a per-zone operating mode (off / heat-only / cool-only / auto) and minimum on/off dwell timers for compressor and heater protection. Sits between the zone temperature sensors and the heater/cooler drive outputs.

Parameters:
TEMP_W, 5, temperature sample width in bits (unsigned)
ZONES, 2, number of independent zones
HEAT_ON, 18, IDLE->HEAT when temp <= HEAT_ON
HEAT_OFF, 20, HEAT->IDLE when temp >= HEAT_OFF
COOL_ON, 22, IDLE->COOL when temp >= COOL_ON
COOL_OFF, 20, COOL->IDLE when temp <= COOL_OFF
MIN_ON, 4, minimum cycles heating/cooling stays high once asserted (>= 1)
MIN_OFF, 2, minimum cycles a zone stays IDLE after leaving HEAT/COOL (>= 1)

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  asynchronous reset, active-high
temperature  input  ZONES*TEMP_W  zone z temperature at [z*TEMP_W +: TEMP_W]
mode  input  2*ZONES  zone z mode at [2z +: 2]: 00 off, 01 heat-only, 10 cool-only, 11 auto
heating  output  ZONES  registered, bit z = zone z heater on
cooling  output  ZONES  registered, bit z = zone z cooler on

Behaviour:
- Clock is clk; reset is rst, asynchronous, active-high.
- Parameter legality (elaboration-time check): HEAT_ON < HEAT_OFF, COOL_OFF < COOL_ON, HEAT_ON < COOL_ON, all < 2**TEMP_W; MIN_ON, MIN_OFF >= 1. Illegal set -> $error.
- Zones fully independent; identical logic replicated ZONES times (generate loop).
- Per zone: state IDLE/HEAT/COOL, dwell counter sized clog2(max(MIN_ON,MIN_OFF)+1), saturating.
- Outputs decoded from registered state: HEAT -> heating=1,cooling=0; COOL -> 0,1; IDLE -> 0,0. heating and cooling never both 1 for a zone.
- Reset: all states IDLE, heating=0, cooling=0, dwell counters saturated (an active state may be entered on the first edge after reset release).
- Latency: condition sampled on edge k -> output changes after edge k (one registered cycle).
- Dwell counter cleared to 0 on every state change, +1 per edge while state unchanged, saturates.
- heat_ok = mode[0], cool_ok = mode[1] (off: neither; auto: both).
- IDLE: if dwell >= MIN_OFF-1 (or first entry after reset): temp <= HEAT_ON and heat_ok -> HEAT; else temp >= COOL_ON and cool_ok -> COOL; else stay. Both conditions cannot hold at once (HEAT_ON < COOL_ON).
- HEAT: temp >= HEAT_OFF and dwell >= MIN_ON-1 -> IDLE. Never direct HEAT->COOL; must pass IDLE and serve MIN_OFF.
- COOL: temp <= COOL_OFF and dwell >= MIN_ON-1 -> IDLE.
- Mode override: in HEAT with heat_ok=0, or COOL with cool_ok=0 -> IDLE on that edge regardless of dwell (safety beats MIN_ON); MIN_OFF then applies normally.
- Net effect: heating/cooling high at least MIN_ON cycles per assertion (unless mode override); IDLE at least MIN_OFF cycles between assertions.
- MIN_ON=MIN_OFF=1, ZONES=1, mode=11 reproduces the legacy single-zone controller edge for edge.
- Reset mid-operation: outputs drop to 0 asynchronously, no wait for clk; dwell history discarded.
- Temperature at exact thresholds: inclusive comparisons as stated (18 enters heat, 20 exits heat/cool, 22 enters cool).

Test Plan:
- Reset/basic heat: rst pulse, zone0 mode=11, temp=17 -> heating[0]=1 after next edge; temp=20 held -> heating[0]=0 exactly 4 cycles after assertion (MIN_ON=4), not earlier even if temp=20 on cycle 1.
- MIN_OFF: zone0 leaves HEAT, temp immediately 17 -> heating[0] stays 0 for 2 cycles, reasserts on 3rd edge.
- Cooling/boundaries: temp=21 -> stays IDLE; temp=22 -> cooling[0]=1; temp=21 for 10 cycles -> stays COOL; temp=20 -> cooling[0]=0.
- Mode gating/override: zone1 mode=10, temp=15 -> no heating; mode=01 while in COOL (temp=25) -> cooling[1]=0 on next edge despite dwell=1; 01 with temp=25 -> no cooling.
- Zone independence: zone0 temp=16, zone1 temp=24, both auto -> heating=2'b01, cooling=2'b10 simultaneously; mode=00 on zone0 only -> heating=2'b00, zone1 unaffected.
- Async reset mid-COOL: assert rst between edges -> cooling drops immediately; release with temp=23 -> cooling reasserts on first edge.
